// File: rtl/hdc_train_ctrl.sv
// Training sequencer for the HDC encode/bundle datapath: groups streamed elements
// into samples, sequences accumulator clear/accumulate/latch and issues AM row writes.
module hdc_train_ctrl #(
   parameter int SMP_SIZE   = 16,
   parameter int SMP_NUM    = 64,
   parameter int CLS_NUM    = 10,
   parameter int CLS_DW     = 4,
   parameter int SMP_DW     = $clog2(SMP_SIZE + 1),
   parameter int SMP_NUM_DW = $clog2(SMP_NUM + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CLS_DW-1:0]     in_label,
   output logic                  acc_clr,
   output logic                  acc_en,
   output logic                  smp_latch,
   output logic                  am_we,
   output logic [CLS_DW-1:0]     am_waddr,
   output logic [SMP_NUM_DW-1:0] smp_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  err_label
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      ACC   = 3'd2,
      LATCH = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [SMP_DW-1:0]       elem_cnt_r;
   logic [SMP_NUM_DW-1:0]   smp_cnt_r;
   logic [CLS_DW-1:0]       lbl_r;
   logic                    err_r;
   logic                    in_ready_r;
   logic                    acc_clr_r;
   logic                    smp_latch_r;
   logic                    am_we_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    beat_s;
   logic                    last_beat_s;
   logic                    last_smp_s;
   logic                    lbl_ok_s;
   logic                    run_start_s;

   assign beat_s      = in_valid & in_ready_r;
   assign last_beat_s = beat_s && (elem_cnt_r == SMP_DW'(SMP_SIZE - 1));
   assign last_smp_s  = (smp_cnt_r == SMP_NUM_DW'(SMP_NUM - 1));
   assign lbl_ok_s    = ({{(32-CLS_DW){1'b0}}, lbl_r} < 32'(CLS_NUM));
   assign run_start_s = (state_r == IDLE) && start && !abort;

   // Next-state decode; abort from any active state returns to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      if (abort && (state_r != IDLE)) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_nxt_s = run_start_s ? CLR : IDLE;
            CLR:     state_nxt_s = ACC;
            ACC:     state_nxt_s = last_beat_s ? LATCH : ACC;
            LATCH:   state_nxt_s = WRITE;
            WRITE:   state_nxt_s = last_smp_s ? DONE : CLR;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State register and strobes registered from the next state, so each strobe
   // coincides exactly with its state and drops asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         acc_clr_r   <= 1'b0;
         in_ready_r  <= 1'b0;
         smp_latch_r <= 1'b0;
         am_we_r     <= 1'b0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         acc_clr_r   <= (state_nxt_s == CLR);
         in_ready_r  <= (state_nxt_s == ACC);
         smp_latch_r <= (state_nxt_s == LATCH);
         am_we_r     <= (state_nxt_s == WRITE) && lbl_ok_s;
         done_r      <= (state_nxt_s == DONE);
         busy_r      <= (state_nxt_s != IDLE);
      end
   end

   // Element/sample counters, label capture and sticky label error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem_cnt_r <= '0;
         smp_cnt_r  <= '0;
         lbl_r      <= '0;
         err_r      <= 1'b0;
      end else begin
         if (state_r == CLR) begin
            elem_cnt_r <= '0;
         end else if (beat_s && !abort) begin
            elem_cnt_r <= elem_cnt_r + SMP_DW'(1);
         end else begin
            elem_cnt_r <= elem_cnt_r;
         end

         if (beat_s && !abort && (elem_cnt_r == '0)) begin
            lbl_r <= in_label;
         end else begin
            lbl_r <= lbl_r;
         end

         if (run_start_s) begin
            smp_cnt_r <= '0;
            err_r     <= 1'b0;
         end else if ((state_r == WRITE) && !abort) begin
            smp_cnt_r <= smp_cnt_r + SMP_NUM_DW'(1);
            err_r     <= err_r | !lbl_ok_s;
         end else begin
            smp_cnt_r <= smp_cnt_r;
            err_r     <= err_r;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign acc_en    = beat_s;
   assign acc_clr   = acc_clr_r;
   assign smp_latch = smp_latch_r;
   assign am_we     = am_we_r;
   assign am_waddr  = lbl_r;
   assign smp_idx   = smp_cnt_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err_label = err_r;

endmodule

// File: tb/tb_hdc_train_ctrl.sv
// Directed bench for hdc_train_ctrl with SMP_SIZE=4, SMP_NUM=3, CLS_NUM=4, CLS_DW=3.
module tb_hdc_train_ctrl;
   localparam int SMP_SIZE = 4;
   localparam int SMP_NUM  = 3;
   localparam int CLS_NUM  = 4;
   localparam int CLS_DW   = 3;
   localparam int SMP_NUM_DW = $clog2(SMP_NUM + 1);

   logic clk = 1'b0;
   logic rst_n, start, abort, in_valid;
   logic [CLS_DW-1:0] in_label;
   logic in_ready, acc_clr, acc_en, smp_latch, am_we, busy, done, err_label;
   logic [CLS_DW-1:0] am_waddr;
   logic [SMP_NUM_DW-1:0] smp_idx;

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int wcyc = 0;
   int done_cnt = 0;
   int d0;
   bit start_in_acc = 1'b0;

   hdc_train_ctrl #(.SMP_SIZE(SMP_SIZE), .SMP_NUM(SMP_NUM), .CLS_NUM(CLS_NUM), .CLS_DW(CLS_DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_label(in_label),
      .acc_clr(acc_clr), .acc_en(acc_en), .smp_latch(smp_latch),
      .am_we(am_we), .am_waddr(am_waddr), .smp_idx(smp_idx),
      .busy(busy), .done(done), .err_label(err_label)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Entered in the CLR cycle; leaves one cycle after WRITE.
   task automatic do_sample(input logic [CLS_DW-1:0] lbl, input bit stall,
                            input bit exp_we, input int exp_acc_cyc);
      int n;
      int acc_cyc;
      chk("clr_strobe", acc_clr, 1);
      chk("clr_ready", in_ready, 0);
      tick;
      n = 0;
      acc_cyc = 0;
      while (n < SMP_SIZE && acc_cyc < 40) begin
         in_valid = stall ? (acc_cyc % 2 == 0) : 1'b1;
         in_label = (n == 0) ? lbl : ~lbl;
         start = start_in_acc;
         #1;
         chk("acc_ready", in_ready, 1);
         chk("acc_en", acc_en, in_valid);
         if (in_valid) n++;
         tick;
         acc_cyc++;
      end
      in_valid = 1'b0;
      in_label = '0;
      start = 1'b0;
      chk("acc_cycles", acc_cyc, exp_acc_cyc);
      chk("latch", smp_latch, 1);
      chk("latch_no_we", am_we, 0);
      tick;
      chk("write_we", am_we, exp_we);
      chk("write_addr", am_waddr, lbl);
      chk("write_no_latch", smp_latch, 0);
      wcyc = cyc;
      tick;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_label = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_waddr", am_waddr, 0);
      chk("rst_idx", smp_idx, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      tick;
      chk("idle_busy", busy, 0);

      // 1: basic run, labels 2,0,3
      start = 1'b1; cyc = 0; tick; start = 1'b0;
      chk("t1_busy", busy, 1);
      do_sample(3'd2, 1'b0, 1'b1, 4); chk("t1_w0cyc", wcyc, 7); chk("t1_idx1", smp_idx, 1);
      do_sample(3'd0, 1'b0, 1'b1, 4); chk("t1_w1cyc", wcyc, 14);
      do_sample(3'd3, 1'b0, 1'b1, 4); chk("t1_w2cyc", wcyc, 21);
      chk("t1_done", done, 1); chk("t1_done_cyc", cyc, 22); chk("t1_idx", smp_idx, 3);
      chk("t1_busy_done", busy, 1);
      tick;
      chk("t1_done_fall", done, 0); chk("t1_idle", busy, 0); chk("t1_idx_hold", smp_idx, 3);

      // 2: stalls on every other ACC cycle
      start = 1'b1; cyc = 0; tick; start = 1'b0;
      chk("t2_idx0", smp_idx, 0);
      do_sample(3'd2, 1'b1, 1'b1, 7); chk("t2_w0cyc", wcyc, 10);
      do_sample(3'd0, 1'b1, 1'b1, 7); chk("t2_w1cyc", wcyc, 20);
      do_sample(3'd3, 1'b1, 1'b1, 7); chk("t2_w2cyc", wcyc, 30);
      chk("t2_done", done, 1);
      tick;
      chk("t2_idle", busy, 0);

      // 3: bad label on the second sample
      start = 1'b1; tick; start = 1'b0;
      do_sample(3'd2, 1'b0, 1'b1, 4);
      chk("t3_err_pre", err_label, 0);
      do_sample(3'd5, 1'b0, 1'b0, 4);
      chk("t3_err_set", err_label, 1); chk("t3_idx", smp_idx, 2);
      do_sample(3'd3, 1'b0, 1'b1, 4);
      chk("t3_done", done, 1); chk("t3_err_hold", err_label, 1);
      tick;
      chk("t3_err_idle", err_label, 1);

      // 4: abort during the second ACC beat of the second sample
      start = 1'b1; tick; start = 1'b0;
      chk("t4_err_clr", err_label, 0);
      do_sample(3'd1, 1'b0, 1'b1, 4);
      tick;
      in_valid = 1'b1; in_label = 3'd2;
      tick;
      abort = 1'b1;
      #1;
      chk("t4_ready_pre", in_ready, 1);
      tick;
      abort = 1'b0; in_valid = 1'b0;
      chk("t4_idle", busy, 0); chk("t4_ready", in_ready, 0); chk("t4_idx_hold", smp_idx, 1);
      for (int i = 0; i < 4; i++) begin
         chk("t4_no_latch", smp_latch, 0);
         chk("t4_no_we", am_we, 0);
         tick;
      end
      start = 1'b1; cyc = 0; tick; start = 1'b0;
      chk("t4_idx_restart", smp_idx, 0);
      do_sample(3'd1, 1'b0, 1'b1, 4);
      do_sample(3'd2, 1'b0, 1'b1, 4);
      do_sample(3'd3, 1'b0, 1'b1, 4); chk("t4_w2cyc", wcyc, 21);
      chk("t4_done", done, 1); chk("t4_idx", smp_idx, 3);
      tick;

      // 6: start during ACC and in the DONE cycle is ignored
      d0 = done_cnt;
      start = 1'b1; cyc = 0; tick; start = 1'b0;
      start_in_acc = 1'b1;
      do_sample(3'd0, 1'b0, 1'b1, 4);
      do_sample(3'd1, 1'b0, 1'b1, 4);
      do_sample(3'd2, 1'b0, 1'b1, 4); chk("t6_w2cyc", wcyc, 21);
      start_in_acc = 1'b0;
      chk("t6_done", done, 1);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("t6_idle", busy, 0);
      tick;
      chk("t6_stay_idle", busy, 0);
      tick;
      chk("t6_one_done", done_cnt - d0, 1);

      // 5: asynchronous reset while in LATCH
      start = 1'b1; tick; start = 1'b0;
      in_valid = 1'b1; in_label = 3'd2;
      repeat (SMP_SIZE + 1) tick;
      in_valid = 1'b0;
      chk("t5_latch", smp_latch, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_latch_fall", smp_latch, 0); chk("t5_busy_fall", busy, 0);
      chk("t5_ready", in_ready, 0); chk("t5_waddr", am_waddr, 0);
      chk("t5_idx", smp_idx, 0); chk("t5_err", err_label, 0);
      @(posedge clk); #1;
      chk("t5_no_we", am_we, 0);
      rst_n = 1'b1;
      tick;
      chk("t5_idle", busy, 0); chk("t5_no_we2", am_we, 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
